apb_master_bridge: RTL and testbench

//  Converts the vmicro16 core's simple memory request (REQ/ACK, addr, data, we)

---
 rtl/apb_master_bridge_pkg.sv | 13 +
 rtl/apb_master_bridge_watchdog.sv | 35 +++
 rtl/apb_master_bridge.sv | 96 +++++++++
 tb/tb_apb_master_bridge.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_bridge_pkg.sv
// Shared definitions for the core-to-APB3 master bridge: FSM state encoding
// and the default read data returned when a transfer times out.
package apb_master_bridge_pkg;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_t;

    localparam logic [15:0] APB_ERR_DATA_DEFAULT = 16'hDEAD;

endpackage

// File: rtl/apb_master_bridge_watchdog.sv
// Saturating ACCESS-phase wait counter; flags expiry when the count reaches
// TIMEOUT_CYCLES-1 so the bridge can terminate a hung transfer.
module apb_master_bridge_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            assign expired = (count_reg == CW'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// Turns the core's single-outstanding REQ/ACK memory request into an APB3
// SETUP/ACCESS transfer, with a watchdog that ends hung ACCESS phases.
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int                   BUS_WIDTH      = 16,
    parameter int                   TIMEOUT_CYCLES = 64,
    parameter logic [BUS_WIDTH-1:0] ERR_DATA       = BUS_WIDTH'(APB_ERR_DATA_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] S_MEM_ADDR,
    input  logic [BUS_WIDTH-1:0] S_MEM_IN,
    input  logic                 S_MEM_WE,
    input  logic                 S_REQ,
    output logic                 S_ACK,
    output logic                 S_ERR,
    output logic [BUS_WIDTH-1:0] S_MEM_OUT,
    output logic                 S_MEM_BUSY,
    output logic [BUS_WIDTH-1:0] M_PADDR,
    output logic                 M_PWRITE,
    output logic                 M_PSELx,
    output logic                 M_PENABLE,
    output logic [BUS_WIDTH-1:0] M_PWDATA,
    input  logic [BUS_WIDTH-1:0] M_PRDATA,
    input  logic                 M_PREADY
);

    apb_state_t state_reg;
    logic       expired;

    apb_master_bridge_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_reg == APB_SETUP),
        .enable ((state_reg == APB_ACCESS) && !M_PREADY),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= APB_IDLE;
            S_ACK      <= 1'b0;
            S_ERR      <= 1'b0;
            S_MEM_OUT  <= '0;
            S_MEM_BUSY <= 1'b0;
            M_PADDR    <= '0;
            M_PWRITE   <= 1'b0;
            M_PSELx    <= 1'b0;
            M_PENABLE  <= 1'b0;
            M_PWDATA   <= '0;
        end else begin
            S_ACK <= 1'b0;
            S_ERR <= 1'b0;
            case (state_reg)
                APB_IDLE: begin
                    if (S_REQ) begin
                        M_PADDR    <= S_MEM_ADDR;
                        M_PWDATA   <= S_MEM_IN;
                        M_PWRITE   <= S_MEM_WE;
                        M_PSELx    <= 1'b1;
                        S_MEM_BUSY <= 1'b1;
                        state_reg  <= APB_SETUP;
                    end
                end
                APB_SETUP: begin
                    M_PENABLE <= 1'b1;
                    state_reg <= APB_ACCESS;
                end
                APB_ACCESS: begin
                    // A ready slave on the expiry cycle completes normally.
                    if (M_PREADY || expired) begin
                        if (!M_PWRITE) begin
                            S_MEM_OUT <= M_PREADY ? M_PRDATA : ERR_DATA;
                        end
                        S_ERR      <= !M_PREADY;
                        S_ACK      <= 1'b1;
                        M_PSELx    <= 1'b0;
                        M_PENABLE  <= 1'b0;
                        S_MEM_BUSY <= 1'b0;
                        state_reg  <= APB_IDLE;
                    end
                end
                default: begin
                    M_PSELx    <= 1'b0;
                    M_PENABLE  <= 1'b0;
                    S_MEM_BUSY <= 1'b0;
                    state_reg  <= APB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge: a transaction-level schedule model
// predicts every output each cycle and a negedge process compares.
module tb_apb_master_bridge;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] s_mem_addr = '0;
    logic [15:0] s_mem_in = '0;
    logic        s_mem_we = 1'b0;
    logic        s_req = 1'b0;
    logic        s_ack, s_err, s_mem_busy;
    logic [15:0] s_mem_out, m_paddr, m_pwdata;
    logic        m_pwrite, m_psel, m_penable;
    logic [15:0] m_prdata = '0;
    logic        m_pready = 1'b0;

    always #5 clk = ~clk;

    apb_master_bridge #(
        .BUS_WIDTH(16),
        .TIMEOUT_CYCLES(T),
        .ERR_DATA(16'hDEAD)
    ) dut (
        .clk(clk), .reset(reset),
        .S_MEM_ADDR(s_mem_addr), .S_MEM_IN(s_mem_in), .S_MEM_WE(s_mem_we),
        .S_REQ(s_req), .S_ACK(s_ack), .S_ERR(s_err), .S_MEM_OUT(s_mem_out),
        .S_MEM_BUSY(s_mem_busy), .M_PADDR(m_paddr), .M_PWRITE(m_pwrite),
        .M_PSELx(m_psel), .M_PENABLE(m_penable), .M_PWDATA(m_pwdata),
        .M_PRDATA(m_prdata), .M_PREADY(m_pready)
    );

    // Model state: expected per-cycle outputs plus retained datapath values.
    logic        e_psel = 0, e_pen = 0, e_busy = 0, e_ack = 0, e_err = 0;
    logic [15:0] md_paddr = '0, md_pwdata = '0, md_out = '0;
    logic        md_pwrite = 0;
    logic        chk_en = 0;
    int          n_chk = 0, n_fail = 0, cyc = 0, n_xfer = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("psel",   16'(m_psel),     16'(e_psel));
            chk("penable",16'(m_penable),  16'(e_pen));
            chk("busy",   16'(s_mem_busy), 16'(e_busy));
            chk("ack",    16'(s_ack),      16'(e_ack));
            chk("err",    16'(s_err),      16'(e_err));
            chk("pwrite", 16'(m_pwrite),   16'(md_pwrite));
            chk("paddr",  m_paddr,  md_paddr);
            chk("pwdata", m_pwdata, md_pwdata);
            chk("mem_out",s_mem_out, md_out);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic junk();
        s_req      = 1'($urandom);
        s_mem_addr = 16'($urandom);
        s_mem_in   = 16'($urandom);
        s_mem_we   = 1'($urandom);
        m_pready   = 1'($urandom);
        m_prdata   = 16'($urandom);
    endtask

    task automatic idle();
        step();
        e_psel = 0; e_pen = 0; e_busy = 0; e_ack = 0; e_err = 0;
        s_req = 0;
        m_pready = 1'($urandom);
        m_prdata = 16'($urandom);
    endtask

    // Issues a request in the current (idle or ACK) cycle. w = wait cycles the
    // slave inserts before PREADY; w >= T means the watchdog ends the transfer.
    // abort_i > 0 asserts reset during that ACCESS cycle instead of completing.
    task automatic do_xfer(input logic [15:0] a, input logic [15:0] d, input logic we,
                           input int w, input logic [15:0] rd, input int abort_i,
                           output int lat);
        int   start;
        int   acc;
        logic to;
        s_req = 1; s_mem_addr = a; s_mem_in = d; s_mem_we = we;
        start = cyc;
        lat = -1;
        step();
        md_paddr = a; md_pwdata = d; md_pwrite = we;
        e_psel = 1; e_pen = 0; e_busy = 1; e_ack = 0; e_err = 0;
        junk();
        to  = (w >= T);
        acc = to ? T : w + 1;
        for (int i = 1; i <= acc; i++) begin
            step();
            e_pen = 1;
            junk();
            m_pready = !to && (i == acc);
            m_prdata = m_pready ? rd : 16'($urandom);
            if (i == abort_i) begin
                #2;
                reset = 0;
                s_req = 0;
                #1;
                chk("rst_psel",    16'(m_psel),     16'h0000);
                chk("rst_penable", 16'(m_penable),  16'h0000);
                chk("rst_busy",    16'(s_mem_busy), 16'h0000);
                e_psel = 0; e_pen = 0; e_busy = 0; e_ack = 0; e_err = 0;
                md_paddr = '0; md_pwdata = '0; md_pwrite = 0; md_out = '0;
                $display("xfer %0d: addr=%h aborted by reset in ACCESS cycle %0d", n_xfer, a, i);
                n_xfer++;
                return;
            end
        end
        step();
        e_psel = 0; e_pen = 0; e_busy = 0; e_ack = 1; e_err = to;
        if (!we) md_out = to ? 16'hDEAD : rd;
        lat = cyc - start;
        s_req = 0;
        m_pready = 1'($urandom);
        m_prdata = 16'($urandom);
        $display("xfer %0d: %s addr=%h wdata=%h waits=%0d latency=%0d timeout=%0d out=%h",
                 n_xfer, we ? "WR" : "RD", a, d, w, lat, to, md_out);
        n_xfer++;
    endtask

    initial begin
        int lat;
        #1 reset = 0;
        chk_en = 1;
        step();
        step();
        reset = 1;
        idle();

        // Read, zero wait states.
        do_xfer(16'h0084, 16'h0000, 1'b0, 0, 16'h1234, 0, lat);
        chk("t1_latency", 16'(lat), 16'd3);
        chk("t1_out", s_mem_out, 16'h1234);
        chk("t1_err", 16'(s_err), 16'h0000);
        idle();

        // Write, three wait states.
        do_xfer(16'h0090, 16'hBEEF, 1'b1, 3, 16'h0000, 0, lat);
        chk("t2_latency", 16'(lat), 16'd6);
        chk("t2_out", s_mem_out, 16'h1234);
        chk("t2_pwdata", m_pwdata, 16'hBEEF);
        idle();

        // Hung slave: watchdog fires after T ACCESS cycles.
        do_xfer(16'h0088, 16'h0000, 1'b0, 50, 16'h0000, 0, lat);
        chk("t3_latency", 16'(lat), 16'd6);
        chk("t3_out", s_mem_out, 16'hDEAD);
        chk("t3_err", 16'(s_err), 16'h0001);
        idle();

        // PREADY exactly on the expiry cycle.
        do_xfer(16'h008C, 16'h0000, 1'b0, T - 1, 16'h5A5A, 0, lat);
        chk("t6_err", 16'(s_err), 16'h0000);
        chk("t6_out", s_mem_out, 16'h5A5A);
        idle();

        // Back-to-back reads with REQ held through the ACK cycle.
        do_xfer(16'h00A0, 16'h0000, 1'b0, 0, 16'h1111, 0, lat);
        do_xfer(16'h00A4, 16'h0000, 1'b0, 1, 16'h2222, 0, lat);
        chk("t4_latency", 16'(lat), 16'd4);
        chk("t4_out", s_mem_out, 16'h2222);
        idle();

        // Reset in the middle of an ACCESS wait, then a clean transfer.
        do_xfer(16'h00B0, 16'h0000, 1'b0, 10, 16'h0000, 2, lat);
        step();
        step();
        reset = 1;
        idle();
        do_xfer(16'h00B4, 16'h0000, 1'b0, 0, 16'h3C3C, 0, lat);
        chk("t5_out", s_mem_out, 16'h3C3C);
        idle();

        // Random traffic.
        for (int k = 0; k < 60; k++) begin
            logic [15:0] a, d, rd;
            logic        we;
            int          w;
            a  = 16'($urandom);
            d  = 16'($urandom);
            rd = 16'($urandom);
            we = 1'($urandom);
            w  = $urandom_range(0, T + 2);
            do_xfer(a, d, we, w, rd, 0, lat);
            if ($urandom_range(0, 1) == 0) begin
                for (int g = 0; g < $urandom_range(1, 3); g++) idle();
            end
        end
        idle();
        idle();
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
